// File: rtl/int_to_float_pkg.sv
// Shared types and constants for the integer-to-float converter.
package int_to_float_pkg;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      NORM  = 2'd1,
      ROUND = 2'd2,
      DONE  = 2'd3
   } state_t;

   localparam int EXP_W  = 8;
   localparam int FRAC_W = 23;

   localparam logic [EXP_W-1:0] EXP_BIAS  = 8'd127;
   // A magnitude with its leading one already at bit 31 has value 2^31.
   localparam logic [EXP_W-1:0] EXP_START = EXP_BIAS + 8'd31;

endpackage

// File: rtl/ieee754_rounder.sv
// Combinational fraction rounder. Define INT_TO_FLOAT_ROUND_EN for
// round-to-nearest-even; otherwise the fraction is truncated.
module ieee754_rounder
   import int_to_float_pkg::*;
(
   input  logic [FRAC_W-1:0] fraction,
   input  logic              guard,
   input  logic              sticky,
   input  logic [EXP_W-1:0]  exp,
   output logic [FRAC_W-1:0] fraction_rnd,
   output logic [EXP_W-1:0]  exp_rnd,
   output logic              inexact
);

   logic              round_up;
   logic              carry;
   logic [FRAC_W-1:0] frac_sum;

`ifdef INT_TO_FLOAT_ROUND_EN
   assign round_up = guard & (sticky | fraction[0]);
`else
   assign round_up = 1'b0;
`endif

   // A carry out of the fraction leaves it all zeros and bumps the exponent.
   assign {carry, frac_sum} = {1'b0, fraction} + {{FRAC_W{1'b0}}, round_up};
   assign fraction_rnd      = frac_sum;
   assign exp_rnd           = exp + {{(EXP_W-1){1'b0}}, carry};
   assign inexact           = guard | sticky;

endmodule

// File: rtl/int_to_float_seq.sv
// Sequential int32 -> IEEE754 single converter, one operand in flight.
// Rounding mode selected by INT_TO_FLOAT_ROUND_EN (see ieee754_rounder).
module int_to_float_seq
   import int_to_float_pkg::*;
#(
   parameter int SHIFT_STEP = 1
)(
   input  logic        clk,
   input  logic        rst_n,
   input  logic        in_valid,
   output logic        in_ready,
   input  logic [31:0] in_int,
   output logic        out_valid,
   input  logic        out_ready,
   output logic [31:0] out_float,
   output logic        out_inexact,
   output logic        busy
);

   localparam logic [EXP_W-1:0] STEP_EXP = EXP_W'(SHIFT_STEP);

   state_t             state;
   logic               sign;
   logic [31:0]        mag;
   logic [EXP_W-1:0]   exp;

   logic [31:0]        in_abs;
   logic               norm_wide;
   logic [FRAC_W-1:0]  frac_rnd;
   logic [EXP_W-1:0]   exp_rnd;
   logic               inexact_rnd;

   // Two's-complement negate; -2^31 wraps onto itself as unsigned 0x80000000.
   assign in_abs    = in_int[31] ? (~in_int + 32'd1) : in_int;
   assign norm_wide = (mag[31 -: SHIFT_STEP] == '0);

   assign in_ready  = (state == IDLE);
   assign busy      = (state != IDLE);

   ieee754_rounder u_rounder (
      .fraction     (mag[30:8]),
      .guard        (mag[7]),
      .sticky       (|mag[6:0]),
      .exp          (exp),
      .fraction_rnd (frac_rnd),
      .exp_rnd      (exp_rnd),
      .inexact      (inexact_rnd)
   );

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state       <= IDLE;
         sign        <= 1'b0;
         mag         <= '0;
         exp         <= '0;
         out_valid   <= 1'b0;
         out_float   <= '0;
         out_inexact <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               if (in_valid) begin
                  sign <= in_int[31];
                  mag  <= in_abs;
                  exp  <= EXP_START;
                  if (in_int == 32'd0) begin
                     out_float   <= '0;
                     out_inexact <= 1'b0;
                     out_valid   <= 1'b1;
                     state       <= DONE;
                  end else begin
                     state <= NORM;
                  end
               end
            end
            NORM: begin
               if (mag[31]) begin
                  state <= ROUND;
               end else if (norm_wide) begin
                  mag <= mag << SHIFT_STEP;
                  exp <= exp - STEP_EXP;
               end else begin
                  mag <= mag << 1;
                  exp <= exp - 8'd1;
               end
            end
            ROUND: begin
               out_float   <= {sign, exp_rnd, frac_rnd};
               out_inexact <= inexact_rnd;
               out_valid   <= 1'b1;
               state       <= DONE;
            end
            DONE: begin
               if (out_ready) begin
                  out_valid <= 1'b0;
                  state     <= IDLE;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule
